// File: rtl/launch_ctrl.sv
// rtl/launch_ctrl.sv - aim/charge/flight/done controller for a launcher game
// Aim and fire buttons drive a power charge; collisions score during flight.
module launch_ctrl #(
  parameter int ANGLE_MAX    = 6,
  parameter int MAX_POWER    = 100,
  parameter int POWER_STEP   = 2,
  parameter int MIN_POWER    = 10,
  parameter int BIRDS        = 3,
  parameter int FLIGHT_TICKS = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       up_op,
  input  logic       down_op,
  input  logic       fire_db,
  input  logic [3:0] collide_op,
  input  logic       landed,
  output logic [1:0] state,
  output logic [2:0] angle,
  output logic [6:0] power,
  output logic       launch,
  output logic [6:0] launch_power,
  output logic [1:0] birds_left,
  output logic [7:0] score
);

  localparam int CW = $clog2(FLIGHT_TICKS + 1);

  typedef enum logic [1:0] {
    S_AIM    = 2'd0,
    S_CHARGE = 2'd1,
    S_FLIGHT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic [2:0]    angle_q, angle_d;
  logic [6:0]    power_q, power_d;
  logic          launch_q;
  logic [6:0]    launch_power_q;
  logic [1:0]    birds_q;
  logic [7:0]    score_q, score_d;
  logic [CW-1:0] flight_cnt_q, flight_cnt_d;
  logic          fire_q;

  logic          fire_rise;
  logic          flight_end;
  logic [2:0]    hits;
  logic [7:0]    power_sum;
  logic [8:0]    score_sum;

  assign fire_rise = fire_db & ~fire_q;

  always_comb begin
    angle_d = angle_q;
    if (up_op && !down_op && angle_q < 3'(ANGLE_MAX)) begin
      angle_d = angle_q + 3'd1;
    end else if (down_op && !up_op && angle_q != 3'd0) begin
      angle_d = angle_q - 3'd1;
    end

    power_sum = {1'b0, power_q} + 8'(POWER_STEP);
    power_d   = (power_sum >= 8'(MAX_POWER)) ? 7'(MAX_POWER) : power_sum[6:0];

    hits = {2'b00, collide_op[0]} + {2'b00, collide_op[1]}
         + {2'b00, collide_op[2]} + {2'b00, collide_op[3]};
    score_sum = {1'b0, score_q} + {6'b000000, hits};
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];

    flight_cnt_d = tick ? flight_cnt_q + CW'(1) : flight_cnt_q;
    // The counter is compared as registered, so the timeout lands one cycle after the last tick.
    flight_end   = landed || (flight_cnt_q >= CW'(FLIGHT_TICKS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_AIM;
      angle_q        <= 3'(ANGLE_MAX / 2);
      power_q        <= 7'd0;
      launch_q       <= 1'b0;
      launch_power_q <= 7'd0;
      birds_q        <= 2'(BIRDS);
      score_q        <= 8'd0;
      flight_cnt_q   <= '0;
      fire_q         <= 1'b0;
    end else begin
      fire_q   <= fire_db;
      launch_q <= 1'b0;
      case (state_q)
        S_AIM: begin
          angle_q <= angle_d;
          if (fire_rise) begin
            state_q <= S_CHARGE;
            power_q <= 7'd0;
          end
        end
        S_CHARGE: begin
          // Release is checked before the tick so a coincident tick never inflates the shot.
          if (!fire_db) begin
            if (power_q >= 7'(MIN_POWER)) begin
              launch_q       <= 1'b1;
              launch_power_q <= power_q;
              flight_cnt_q   <= '0;
              state_q        <= S_FLIGHT;
            end else begin
              power_q <= 7'd0;
              state_q <= S_AIM;
            end
          end else if (tick) begin
            power_q <= power_d;
          end
        end
        S_FLIGHT: begin
          score_q      <= score_d;
          flight_cnt_q <= flight_cnt_d;
          if (flight_end) begin
            birds_q <= birds_q - 2'd1;
            power_q <= 7'd0;
            state_q <= (birds_q == 2'd1) ? S_DONE : S_AIM;
          end
        end
        S_DONE: begin
          if (fire_rise) begin
            birds_q <= 2'(BIRDS);
            score_q <= 8'd0;
            state_q <= S_AIM;
          end
        end
        default: state_q <= S_AIM;
      endcase
    end
  end

  assign state        = state_q;
  assign angle        = angle_q;
  assign power        = power_q;
  assign launch       = launch_q;
  assign launch_power = launch_power_q;
  assign birds_left   = birds_q;
  assign score        = score_q;

endmodule
